// File: rtl/io_transfer_buffer.sv
`default_nettype none
// ============================================================================
// Module      : io_transfer_buffer
// Description : Input-side transfer buffer for the single-cycle MIPS
//               datapath. Words from an external device are accepted over a
//               valid/ready handshake into a small FIFO. The head word is
//               presented to the writeback mux as TransfBuffer. A 3-bit
//               Interruption code is also decoded for that mux and for the
//               control unit.
//               Optional feature macro: TRANSF_BUFFER_WATERMARK_EN
//               (interrupt trigger becomes Count >= WATERMARK).
// Revision    : 1.0 - initial release
// ============================================================================
module io_transfer_buffer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int WATERMARK = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         DevData,
  input  logic                     DevValid,
  output logic                     DevReady,
  input  logic                     Pop,
  input  logic                     IrqAck,
  input  logic                     Clear,
  output logic [WIDTH-1:0]         TransfBuffer,
  output logic [2:0]               Interruption,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  // Interrupt handshake states
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_PEND   = 2'd1;
  localparam logic [1:0] c_SERVED = 2'd2;

  // Interruption codes seen by the writeback mux / control unit
  localparam logic [2:0] c_IRQ_NONE  = 3'b000;
  localparam logic [2:0] c_IRQ_AVAIL = 3'b001;
  localparam logic [2:0] c_IRQ_FULL  = 3'b010;
  localparam logic [2:0] c_IRQ_UFLOW = 3'b011;

  // Fill level at which a pending interrupt is raised
`ifdef TRANSF_BUFFER_WATERMARK_EN
  localparam logic [AW:0] c_TRIGGER = (AW+1)'(WATERMARK);
`else
  localparam logic [AW:0] c_TRIGGER = c_CNT_ONE;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_countNext;
  logic             r_err;
  logic             w_errNext;
  logic [1:0]       r_state;
  logic [1:0]       w_stateNext;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_underflow;

  // Occupancy flags come straight from the registered count
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);

  // Handshake qualification: a pop in the same cycle never frees a full slot
  assign w_push      = DevValid && !w_full;
  assign w_pop       = Pop && !w_empty;
  assign w_underflow = Pop && w_empty;

  // Occupancy after this edge (ignoring Clear, which overrides it)
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + c_CNT_ONE;
      2'b01:   w_countNext = r_count - c_CNT_ONE;
      default: w_countNext = r_count;
    endcase
  end

  // Sticky underflow flag: a new underflow wins over an acknowledge
  always_comb begin
    w_errNext = r_err;
    if (w_underflow) begin
      w_errNext = 1'b1;
    end else if (IrqAck) begin
      w_errNext = 1'b0;
    end
  end

  // Interrupt handshake: conditions are judged on the post-edge occupancy.
  // An acknowledge while err is set only clears err; PEND is kept.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_countNext >= c_TRIGGER) begin
          w_stateNext = c_PEND;
        end
      end
      c_PEND: begin
        if (IrqAck && !r_err) begin
          w_stateNext = c_SERVED;
        end else if (w_countNext == '0) begin
          w_stateNext = c_IDLE;
        end
      end
      c_SERVED: begin
        if (w_countNext == '0) begin
          w_stateNext = c_IDLE;
        end
      end
      default: w_stateNext = c_IDLE;
    endcase
  end

  // Storage write; contents are not reset since only valid slots are read
  always_ff @(posedge Clock) begin
    if (w_push && !Clear) begin
      r_mem[r_wrPtr] <= DevData;
    end
  end

  // Pointer and occupancy registers; Clear flushes everything
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (Clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_PTR_ONE;
      end
      r_count <= w_countNext;
    end
  end

  // Error flag and interrupt state registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_err   <= 1'b0;
      r_state <= c_IDLE;
    end else if (Clear) begin
      r_err   <= 1'b0;
      r_state <= c_IDLE;
    end else begin
      r_err   <= w_errNext;
      r_state <= w_stateNext;
    end
  end

  // Interruption decode from registered state only, in priority order
  always_comb begin
    Interruption = c_IRQ_NONE;
    if (r_err) begin
      Interruption = c_IRQ_UFLOW;
    end else if ((r_state == c_PEND) && w_full) begin
      Interruption = c_IRQ_FULL;
    end else if (r_state == c_PEND) begin
      Interruption = c_IRQ_AVAIL;
    end
  end

  // Head word is read combinationally so the CPU sees it in its pop cycle
  assign TransfBuffer = w_empty ? '0 : r_mem[r_rdPtr];
  assign DevReady     = !w_full;
  assign Empty        = w_empty;
  assign Full         = w_full;
  assign Count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_io_transfer_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_transfer_buffer
// Description : Self-checking bench for io_transfer_buffer with a queue-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_transfer_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int WM    = 2;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [WIDTH-1:0]  DevData;
  logic              DevValid;
  logic              DevReady;
  logic              Pop;
  logic              IrqAck;
  logic              Clear;
  logic [WIDTH-1:0]  TransfBuffer;
  logic [2:0]        Interruption;
  logic [2:0]        Count;
  logic              Empty;
  logic              Full;

  io_transfer_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WATERMARK(WM)
  ) dut (
    .Clock(Clock), .Reset(Reset), .DevData(DevData), .DevValid(DevValid),
    .DevReady(DevReady), .Pop(Pop), .IrqAck(IrqAck), .Clear(Clear),
    .TransfBuffer(TransfBuffer), .Interruption(Interruption), .Count(Count),
    .Empty(Empty), .Full(Full)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, sticky error, interrupt pending/served
  logic [WIDTH-1:0] q[$];
  bit mErr, mPend, mServed;

  function automatic int trigLevel();
`ifdef TRANSF_BUFFER_WATERMARK_EN
    return WM;
`else
    return 1;
`endif
  endfunction

  task automatic modelReset();
    q.delete();
    mErr = 0; mPend = 0; mServed = 0;
  endtask

  task automatic modelEdge(input logic v, input logic [WIDTH-1:0] d,
                           input logic p, input logic a, input logic c);
    bit wasFull, wasEmpty, errBefore;
    int n;
    if (c) begin
      modelReset();
      return;
    end
    wasFull   = (q.size() == DEPTH);
    wasEmpty  = (q.size() == 0);
    errBefore = mErr;
    if (p && !wasEmpty) void'(q.pop_front());
    if (v && !wasFull) q.push_back(d);
    if (p && wasEmpty) mErr = 1;
    else if (a)        mErr = 0;
    n = q.size();
    if (mPend) begin
      if (a && !errBefore) begin mPend = 0; mServed = 1; end
      else if (n == 0) mPend = 0;
    end else if (mServed) begin
      if (n == 0) mServed = 0;
    end else if (n >= trigLevel()) begin
      mPend = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] expIrq;
    int n;
    n = q.size();
    if (mErr)                      expIrq = 3;
    else if (mPend && n == DEPTH)  expIrq = 2;
    else if (mPend)                expIrq = 1;
    else                           expIrq = 0;
    chk({tag, ".count"}, 32'(Count), 32'(n));
    chk({tag, ".empty"}, 32'(Empty), 32'(n == 0));
    chk({tag, ".full"},  32'(Full),  32'(n == DEPTH));
    chk({tag, ".ready"}, 32'(DevReady), 32'(n != DEPTH));
    chk({tag, ".head"},  TransfBuffer, (n == 0) ? 32'h0 : q[0]);
    chk({tag, ".irq"},   32'(Interruption), expIrq);
  endtask

  // One clock: apply inputs, clock edge, update model, sample 1 ns later
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic p, input logic a, input logic c);
    DevValid = v; DevData = d; Pop = p; IrqAck = a; Clear = c;
    @(posedge Clock);
    modelEdge(v, d, p, a, c);
    #1;
    checkAll(tag);
  endtask

  initial begin
    Reset = 1'b0; DevValid = 0; DevData = '0; Pop = 0; IrqAck = 0; Clear = 0;
    modelReset();
    #1;
    checkAll("reset");
    @(posedge Clock); #1;
    Reset = 1'b1;

    // Fill to full, then a fifth word that must be held off
    for (int i = 1; i <= 4; i++) step("fill", 1, 32'hA5A5_0000 + 32'(i), 0, 0, 0);
    step("hold5", 1, 32'hDEAD_BEEF, 0, 0, 0);
    step("hold5b", 1, 32'hDEAD_BEEF, 0, 0, 0);

    // Drain in order; head is visible in the cycle before each pop edge
    for (int i = 0; i < 4; i++) step("drain", 0, '0, 1, 0, 0);

    // Underflow with a concurrent push, then acknowledge the error
    step("uflow", 1, 32'h0000_1234, 1, 0, 0);
    step("ackerr", 0, '0, 0, 1, 0);
    step("ackpend", 0, '0, 0, 1, 0);
    step("popone", 0, '0, 1, 0, 0);

    // Interleaved push / pop / push+pop, wrapping the pointers
    step("mix1", 1, 32'h1111_0001, 0, 0, 0);
    step("mix2", 1, 32'h1111_0002, 1, 0, 0);
    step("mix3", 1, 32'h1111_0003, 0, 0, 0);
    step("mix4", 0, '0, 1, 0, 0);
    step("mix5", 1, 32'h1111_0004, 1, 0, 0);
    step("mix6", 1, 32'h1111_0005, 1, 0, 0);

    // Clear dominates a concurrent push and pop
    step("clear", 1, 32'h2222_0000, 1, 0, 1);
    step("after_clear", 1, 32'h2222_0001, 0, 0, 0);
    step("push2", 1, 32'h2222_0002, 0, 0, 0);

    // Asynchronous reset mid-cycle, checked before the next edge
    DevValid = 1; DevData = 32'h3333_0000; Pop = 1;
    #2;
    Reset = 1'b0;
    modelReset();
    #1;
    checkAll("async_reset");
    @(posedge Clock); #1;
    Reset = 1'b1;
    DevValid = 0; Pop = 0;
    checkAll("reset_hold");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 9) < 6),
           $urandom(),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
